// File: rtl/bram_pkg.sv
// Shared types and helpers for the byte-enable simple-dual-port BRAM.
//   num_bytes()  : number of write-enable lanes in a word
//   clr_state_t  : clear sequencer states
//   WF_*         : collision policy selectors for WRITE_FIRST
package bram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_t;

    localparam int WF_READ_FIRST  = 0;
    localparam int WF_WRITE_FIRST = 1;

    function automatic int num_bytes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/bram_clear_sequencer.sv
// Reset-time clear sequencer: after rst walks the address space once,
// emitting a zero-write per cycle, then parks in READY.
//   clk, rst  : clock, synchronous active-high reset
//   busy      : high while clearing (port requests must be ignored)
//   clr_we    : clear write strobe
//   clr_addr  : clear write address
module bram_clear_sequencer
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DEPTH          = 1024,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    // One extra counter bit so DEPTH == 2**ADDR_WIDTH still has a
    // representable last index and comparison.
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    clr_state_t            state;
    logic [ADDR_WIDTH:0]   cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            if (CLEAR_ON_RESET != 0) begin
                state <= ST_CLEAR;
                busy  <= 1'b1;
            end else begin
                state <= ST_READY;
                busy  <= 1'b0;
            end
        end else begin
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ST_READY;
                        busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // busy is exactly the CLEAR state, so it doubles as the write strobe.
    assign clr_we   = busy;
    assign clr_addr = cnt[ADDR_WIDTH-1:0];

endmodule

// File: rtl/bram_sdp_be_pipelined.sv
// Simple-dual-port block RAM with per-byte write enables on port A,
// 1- or 2-cycle read latency on port B with a valid strobe, selectable
// same-address collision policy and a reset-time zero clear.
//   clk, rst         : clock, synchronous active-high reset
//   busy             : clear in progress, port requests ignored
//   we_a/be_a/addr_a/din_a : write port
//   en_b/addr_b      : read request
//   dout_b/valid_b   : read data (held between reads) and its strobe
module bram_sdp_be_pipelined
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int BYTE_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int DEPTH          = 1024,
    parameter int OUT_REG        = 1,
    parameter int WRITE_FIRST    = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NB            = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    input  logic                  we_a,
    input  logic [NB-1:0]         be_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    input  logic                  en_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  valid_b
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam int                  STAGES  = (OUT_REG != 0) ? 2 : 1;

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] ram [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    bram_clear_sequencer #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clr (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic a_in_range, b_in_range, wr_ok, rd_ok;

    assign a_in_range = {1'b0, addr_a} < DEPTH_L;
    assign b_in_range = {1'b0, addr_b} < DEPTH_L;
    assign wr_ok      = we_a & ~busy & ~rst & a_in_range;
    assign rd_ok      = en_b & ~busy & ~rst;

    // Clear writes take priority; port A is already masked while busy.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            ram[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (be_a[i])
                    ram[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Read word: out-of-range returns zero; write-first overlays the
    // enabled bytes of a same-cycle write to the same address.
    logic [DATA_WIDTH-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (b_in_range) begin
            rd_word = ram[addr_b];
            if (WRITE_FIRST == WF_WRITE_FIRST && wr_ok && addr_a == addr_b) begin
                for (int i = 0; i < NB; i++) begin
                    if (be_a[i])
                        rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (rst)
            rd_q <= '0;
        else if (rd_ok)
            rd_q <= rd_word;
    end

    // vld_pipe[0] is the accepted request; bit s is valid after s edges.
    logic [STAGES:0] vld_pipe;

    assign vld_pipe[0] = rd_ok;

    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe[STAGES:1] <= '0;
        else
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_q;
            always_ff @(posedge clk) begin
                if (rst)
                    out_q <= '0;
                else if (vld_pipe[1])
                    out_q <= rd_q;
            end
            assign dout_b = out_q;
        end else begin : g_no_out_reg
            assign dout_b = rd_q;
        end
    endgenerate

    assign valid_b = vld_pipe[STAGES];

endmodule
